// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared constants and types for the MIPS IF stage with prefetch queue.
// Default widths/depths live here so the top and its callers agree on them.
package fetch_prefetch_unit_pkg;

  localparam int unsigned NB_BITS_DEF      = 32;
  localparam int unsigned NB_JUMP          = 26;
  localparam int unsigned RAM_FETCH_DEPTH  = 10;
  localparam int unsigned PREFETCH_Q_DEPTH = 4;
  localparam logic [31:0] NOP_OPERATION    = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFID_HOLD,
    IFID_LOAD,
    IFID_BUBBLE
  } ifid_op_e;

endpackage

// File: rtl/fetch_prefetch_unit_queue.sv
// Synchronous FIFO of {pc, instr} prefetch entries with a synchronous clear.
// Clear wins over push/pop; pointers wrap naturally since DEPTH is a power of 2.
module fetch_prefetch_queue
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = PREFETCH_Q_DEPTH,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_clear,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push & ~o_full  & ~i_clear;
  assign w_pop   = i_pop  & ~o_empty & ~i_clear;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// MIPS IF stage: credit-based prefetch from a sync-read instruction RAM into a
// small queue feeding the IF/ID register; redirects squash all wrong-path work.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int unsigned          NB_BITS   = NB_BITS_DEF,
  parameter int unsigned          NB_JMP    = NB_JUMP,
  parameter int unsigned          RAM_DEPTH = RAM_FETCH_DEPTH,
  parameter int unsigned          Q_DEPTH   = PREFETCH_Q_DEPTH,
  parameter string                INIT_FILE = "",
  parameter logic [NB_BITS-1:0]   NOP_INSTR = NB_BITS'(NOP_OPERATION)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NB_BITS-1:0]       i_brq_addr,
  input  logic [NB_JMP-1:0]        i_jmp_addr,
  input  logic                     i_ctr_beq,
  input  logic                     i_ctr_jmp,
  input  logic                     i_ctr_flush,
  input  logic                     i_pc_we,
  input  logic                     i_if_id_we,
  output logic [NB_BITS-1:0]       o_if_id_pc,
  output logic [NB_BITS-1:0]       o_if_id_instr,
  output logic                     o_if_id_valid,
  output logic [NB_BITS-1:0]       o_pc,
  output logic [$clog2(Q_DEPTH):0] o_q_count
);

  localparam int unsigned AW    = RAM_DEPTH - 2;
  localparam int unsigned WORDS = 2 ** AW;
  localparam int unsigned QCW   = $clog2(Q_DEPTH) + 1;
  localparam logic [QCW:0] QLIM = (QCW + 1)'(Q_DEPTH);

  logic [NB_BITS-1:0]   r_pc;
  logic [NB_BITS-1:0]   r_pend_pc;
  logic                 r_pend_v;
  logic [NB_BITS-1:0]   r_ram_dout;
  logic [NB_BITS-1:0]   r_if_id_pc;
  logic [NB_BITS-1:0]   r_if_id_instr;
  logic                 r_if_id_valid;
  logic [NB_BITS-1:0]   r_imem [WORDS];

  logic                 w_redirect;
  logic                 w_issue;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_q_empty;
  logic                 w_q_full;
  logic [QCW-1:0]       w_q_count;
  logic [QCW:0]         w_credit_used;
  logic [2*NB_BITS-1:0] w_q_dout;
  logic [NB_BITS-1:0]   w_target;
  logic [NB_BITS-1:0]   w_pc_plus4;
  logic [AW-1:0]        w_ram_addr;
  logic                 w_ram_we;
  logic [NB_BITS-1:0]   w_ram_din;
  logic                 w_unused_init;
  ifid_op_e             w_ifid_op;

  assign w_unused_init = (INIT_FILE != "");

  assign w_redirect    = i_pc_we & (i_ctr_jmp | i_ctr_beq);
  assign w_target      = i_ctr_jmp ? {r_if_id_pc[NB_BITS-1:NB_JMP], i_jmp_addr} : i_brq_addr;
  assign w_pc_plus4    = r_pc + NB_BITS'(4);
  // Credit counts the in-flight read but not a same-cycle pop, so a push can never find the queue full.
  assign w_credit_used = {1'b0, w_q_count} + {{QCW{1'b0}}, r_pend_v};
  assign w_issue       = i_pc_we & ~w_redirect & ~w_q_full & (w_credit_used < QLIM);
  assign w_push        = r_pend_v & ~w_redirect;
  assign w_ram_addr    = r_pc[RAM_DEPTH-1:2];
  assign w_ram_we      = 1'b0;
  assign w_ram_din     = '0;

  always_ff @(posedge i_clk) begin
    if (w_ram_we) r_imem[w_ram_addr] <= w_ram_din;
    if (w_issue)  r_ram_dout         <= r_imem[w_ram_addr];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc      <= '0;
      r_pend_v  <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      if (w_redirect)   r_pc <= w_target;
      else if (w_issue) r_pc <= w_pc_plus4;
      r_pend_v <= w_issue;
      if (w_issue) r_pend_pc <= w_pc_plus4;
    end
  end

  fetch_prefetch_queue #(
    .DEPTH (Q_DEPTH),
    .WIDTH (2 * NB_BITS)
  ) u_queue (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_redirect),
    .i_din   ({r_pend_pc, r_ram_dout}),
    .o_dout  (w_q_dout),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  always_comb begin
    w_ifid_op = IFID_HOLD;
    if (i_ctr_flush)     w_ifid_op = IFID_BUBBLE;
    else if (i_if_id_we) w_ifid_op = w_q_empty ? IFID_BUBBLE : IFID_LOAD;
  end

  assign w_pop = (w_ifid_op == IFID_LOAD);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_if_id_pc    <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
    end else begin
      case (w_ifid_op)
        IFID_LOAD: begin
          r_if_id_pc    <= w_q_dout[2*NB_BITS-1:NB_BITS];
          r_if_id_instr <= w_q_dout[NB_BITS-1:0];
          r_if_id_valid <= 1'b1;
        end
        IFID_BUBBLE: begin
          r_if_id_instr <= NOP_INSTR;
          r_if_id_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_if_id_pc    = r_if_id_pc;
  assign o_if_id_instr = r_if_id_instr;
  assign o_if_id_valid = r_if_id_valid;
  assign o_pc          = r_pc;
  assign o_q_count     = w_q_count;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench for fetch_prefetch_unit: a queue-based reference model
// predicts each cycle's state and every instruction loaded into IF/ID.
module tb_fetch_prefetch_unit;

  localparam int NB    = 32;
  localparam int NJ    = 26;
  localparam int RD    = 10;
  localparam int QD    = 4;
  localparam int WORDS = 1 << (RD - 2);
  localparam logic [31:0] NOP = 32'h0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] brq_addr = '0;
  logic [NJ-1:0] jmp_addr = '0;
  logic          ctr_beq = 1'b0, ctr_jmp = 1'b0, ctr_flush = 1'b0;
  logic          pc_we = 1'b0, if_id_we = 1'b0;
  logic [NB-1:0] if_id_pc, if_id_instr, pc;
  logic          if_id_valid;
  logic [2:0]    q_count;

  fetch_prefetch_unit #(
    .NB_BITS   (NB),
    .NB_JMP    (NJ),
    .RAM_DEPTH (RD),
    .Q_DEPTH   (QD),
    .INIT_FILE (""),
    .NOP_INSTR (NOP)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_brq_addr    (brq_addr),
    .i_jmp_addr    (jmp_addr),
    .i_ctr_beq     (ctr_beq),
    .i_ctr_jmp     (ctr_jmp),
    .i_ctr_flush   (ctr_flush),
    .i_pc_we       (pc_we),
    .i_if_id_we    (if_id_we),
    .o_if_id_pc    (if_id_pc),
    .o_if_id_instr (if_id_instr),
    .o_if_id_valid (if_id_valid),
    .o_pc          (pc),
    .o_q_count     (q_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    logic [31:0] fpc;
    int          cnt;
    logic        v;
    logic [31:0] ifpc;
    logic [31:0] ifinstr;
  } st_t;

  ent_t exp_ld[$];
  st_t  exp_st[$];
  int   total = 0;
  int   bad   = 0;

  ent_t        mq[$];
  bit          m_pend;
  ent_t        m_pend_ent;
  logic [31:0] m_pc;
  ent_t        m_ifid;
  bit          m_ifv;
  logic [31:0] mem [WORDS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_pend = 0;
    m_pend_ent = '{pc: 32'h0, instr: 32'h0};
    m_pc = 32'h0;
    m_ifid = '{pc: 32'h0, instr: NOP};
    m_ifv = 0;
  endfunction

  function automatic void model_step(bit pcwe, bit beq, bit jmp, bit flush, bit ifwe,
                                     logic [31:0] brq, logic [25:0] ja);
    bit          redir = pcwe && (jmp || beq);
    int          occ   = mq.size();
    bit          take  = ifwe && !flush && (occ > 0);
    logic [31:0] tgt   = jmp ? {m_ifid.pc[31:26], ja} : brq;
    bit          issue = pcwe && !redir && ((occ + int'(m_pend)) < QD);
    st_t         s;
    if (flush) begin
      m_ifid.instr = NOP;
      m_ifv = 0;
    end else if (ifwe) begin
      if (take) begin
        m_ifid = mq[0];
        m_ifv = 1;
        exp_ld.push_back(mq[0]);
      end else begin
        m_ifid.instr = NOP;
        m_ifv = 0;
      end
    end
    if (redir) mq.delete();
    else begin
      if (take) void'(mq.pop_front());
      if (m_pend) mq.push_back(m_pend_ent);
    end
    if (issue) begin
      m_pend_ent = '{pc: m_pc + 32'd4, instr: mem[(m_pc >> 2) % WORDS]};
      m_pc = m_pc + 32'd4;
    end
    m_pend = issue;
    if (redir) m_pc = tgt;
    s = '{fpc: m_pc, cnt: mq.size(), v: m_ifv, ifpc: m_ifid.pc, ifinstr: m_ifid.instr};
    exp_st.push_back(s);
  endfunction

  task automatic step(input bit pcwe, input bit beq, input bit jmp, input bit flush,
                      input bit ifwe, input logic [31:0] brq, input logic [25:0] ja);
    pc_we = pcwe; ctr_beq = beq; ctr_jmp = jmp; ctr_flush = flush;
    if_id_we = ifwe; brq_addr = brq; jmp_addr = ja;
    model_step(pcwe, beq, jmp, flush, ifwe, brq, ja);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 1, 32'h0, 26'h0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},       pc, 32'h0);
    chk({tag, "_qcount"},   {29'h0, q_count}, 32'h0);
    chk({tag, "_valid"},    {31'h0, if_id_valid}, 32'h0);
    chk({tag, "_ifinstr"},  if_id_instr, NOP);
    chk({tag, "_ifpc"},     if_id_pc, 32'h0);
  endtask

  // Monitor: one expected state per stepped edge; IF/ID loads checked in order.
  initial begin
    logic s_we, s_fl;
    st_t  st;
    ent_t e;
    forever begin
      @(posedge clk);
      s_we = if_id_we;
      s_fl = ctr_flush;
      #1;
      if (exp_st.size() > 0) begin
        st = exp_st.pop_front();
        chk("pc",      pc, st.fpc);
        chk("qcount",  {29'h0, q_count}, st.cnt);
        chk("valid",   {31'h0, if_id_valid}, {31'h0, st.v});
        chk("ifinstr", if_id_instr, st.ifinstr);
        chk("ifpc",    if_id_pc, st.ifpc);
        if (s_we && !s_fl && if_id_valid) begin
          if (exp_ld.size() == 0) begin
            total++;
            bad++;
            $display("FAIL load: unexpected instr %h pc %h", if_id_instr, if_id_pc);
          end else begin
            e = exp_ld.pop_front();
            chk("load_pc",    if_id_pc, e.pc);
            chk("load_instr", if_id_instr, e.instr);
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < WORDS; k++) begin
      mem[k] = k + 1;
      dut.r_imem[k] = k + 1;
    end
    repeat (3) @(negedge clk);
    model_reset();
    chk_reset_state("reset");
    rst_n = 1'b1;

    run(10);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 32'h0, 26'h0);
    step(0, 0, 0, 0, 1, 32'h0, 26'h0);
    step(1, 1, 0, 0, 0, 32'h40, 26'h0);
    run(6);
    step(1, 1, 1, 0, 0, 32'h40, 26'h80);
    run(6);
    step(1, 0, 0, 1, 1, 32'h0, 26'h0);
    step(1, 0, 0, 1, 0, 32'h0, 26'h0);
    run(4);

    #2 rst_n = 1'b0;
    #1 chk_reset_state("midreset");
    @(negedge clk);
    pc_we = 0; ctr_beq = 0; ctr_jmp = 0; ctr_flush = 0; if_id_we = 0;
    model_reset();
    rst_n = 1'b1;
    run(8);

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 8) != 0, ($urandom % 16) == 0, ($urandom % 24) == 0,
           ($urandom % 16) == 0, ($urandom % 4) != 0,
           {22'h0, 8'($urandom_range(0, 255)), 2'b00},
           {16'h0, 8'($urandom_range(0, 255)), 2'b00});
    end
    step(0, 0, 0, 0, 0, 32'h0, 26'h0);
    @(negedge clk);
    chk("pending_loads", exp_ld.size(), 32'h0);
    chk("pending_states", exp_st.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
